// File: rtl/velocity_broadcast_ctrl.sv
// velocity_broadcast_ctrl: transmit side of the motion-update broadcast bus.
// Walks every source cell cache, reads the particle count at address 0,
// then streams each particle record onto the broadcast bus.
// Optional build macro MU_COUNT_CHECK_EN: counts above PARTICLE_NUM are
// clamped and flagged on a sticky out_count_error output.
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | waiting for in_start
// CNT_REQ   | count read (address 0) issued to the current cell
// CNT_WAIT  | count read in flight
// CNT_LATCH | count returned: skip the cell, read particles, or finish
// PART_RD   | particle reads at addresses 1..N, one per cycle
// DRAIN     | reads stopped, waiting for the last particle data
// COOLDOWN  | receivers commit their count and swap buffers
module velocity_broadcast_ctrl #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 8,
  parameter int CELL_ID_WIDTH  = 4,
  parameter int PARTICLE_NUM   = 220,
  parameter int NUM_CELLS      = 8,
  parameter int CELL_IDX_WIDTH = 3
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic                                        in_start,
  output logic [CELL_IDX_WIDTH-1:0]                   out_rd_cell,
  output logic [ADDR_WIDTH-1:0]                       out_rd_address,
  output logic                                        out_rden,
  input  logic [3*DATA_WIDTH+3*CELL_ID_WIDTH-1:0]     in_rd_data,
  output logic                                        out_motion_update_enable,
  output logic [3*DATA_WIDTH-1:0]                     out_data,
  output logic [3*CELL_ID_WIDTH-1:0]                  out_data_dst_cell,
  output logic                                        out_data_valid,
  output logic                                        out_busy,
  output logic                                        out_done
`ifdef MU_COUNT_CHECK_EN
  ,
  output logic                                        out_count_error
`endif
);

  localparam int RD_W = 3*DATA_WIDTH + 3*CELL_ID_WIDTH;

  typedef enum logic [2:0] {
    IDLE, CNT_REQ, CNT_WAIT, CNT_LATCH, PART_RD, DRAIN, COOLDOWN
  } state_t;

  state_t                      state, state_nxt;
  logic [CELL_IDX_WIDTH-1:0]   cell_nxt;
  logic [ADDR_WIDTH-1:0]       addr_nxt;
  logic                        rden_nxt, en_nxt, busy_nxt, done_nxt;
  logic [ADDR_WIDTH-1:0]       rem, rem_nxt;
  logic [1:0]                  tmr, tmr_nxt;
  logic [ADDR_WIDTH-1:0]       count_eff;
  logic                        last_cell;
  logic [1:0]                  pend;
`ifdef MU_COUNT_CHECK_EN
  logic                        count_over;
  logic                        err_nxt;
`endif

  assign last_cell = (out_rd_cell == CELL_IDX_WIDTH'(NUM_CELLS - 1));

  // Effective particle count taken from the address-0 word
  always_comb begin
    count_eff = in_rd_data[ADDR_WIDTH-1:0];
`ifdef MU_COUNT_CHECK_EN
    count_over = 1'b0;
    if (in_rd_data[ADDR_WIDTH-1:0] > ADDR_WIDTH'(PARTICLE_NUM)) begin
      count_eff  = ADDR_WIDTH'(PARTICLE_NUM);
      count_over = 1'b1;
    end
`endif
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (in_start) state_nxt = CNT_REQ;
      CNT_REQ:   state_nxt = CNT_WAIT;
      CNT_WAIT:  state_nxt = CNT_LATCH;
      CNT_LATCH: begin
        if (count_eff != '0) state_nxt = PART_RD;
        else if (last_cell)  state_nxt = COOLDOWN;
        else                 state_nxt = CNT_REQ;
      end
      PART_RD:   if (rem == '0) state_nxt = DRAIN;
      DRAIN:     if (tmr == 2'd0) state_nxt = last_cell ? COOLDOWN : CNT_REQ;
      COOLDOWN:  if (tmr == 2'd0) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs and the down-counters
  always_comb begin
    cell_nxt = out_rd_cell;
    addr_nxt = out_rd_address;
    rden_nxt = 1'b0;
    en_nxt   = out_motion_update_enable;
    busy_nxt = out_busy;
    done_nxt = 1'b0;
    rem_nxt  = rem;
    tmr_nxt  = tmr;
`ifdef MU_COUNT_CHECK_EN
    err_nxt  = out_count_error;
`endif
    case (state)
      IDLE: begin
        if (in_start) begin
          cell_nxt = '0;
          addr_nxt = '0;
          rden_nxt = 1'b1;
          en_nxt   = 1'b1;
          busy_nxt = 1'b1;
`ifdef MU_COUNT_CHECK_EN
          err_nxt  = 1'b0;
`endif
        end
      end
      CNT_LATCH: begin
`ifdef MU_COUNT_CHECK_EN
        if (count_over) err_nxt = 1'b1;
`endif
        if (count_eff != '0) begin
          rden_nxt = 1'b1;
          addr_nxt = ADDR_WIDTH'(1);
          rem_nxt  = count_eff - ADDR_WIDTH'(1);
        end else if (last_cell) begin
          en_nxt   = 1'b0;
          done_nxt = 1'b1;
          tmr_nxt  = 2'd2;
        end else begin
          cell_nxt = out_rd_cell + CELL_IDX_WIDTH'(1);
          addr_nxt = '0;
          rden_nxt = 1'b1;
        end
      end
      PART_RD: begin
        if (rem == '0) begin
          // last cell waits one extra cycle so done follows the final valid
          tmr_nxt = last_cell ? 2'd2 : 2'd1;
        end else begin
          rden_nxt = 1'b1;
          addr_nxt = out_rd_address + ADDR_WIDTH'(1);
          rem_nxt  = rem - ADDR_WIDTH'(1);
        end
      end
      DRAIN: begin
        if (tmr == 2'd0) begin
          if (last_cell) begin
            en_nxt   = 1'b0;
            done_nxt = 1'b1;
            tmr_nxt  = 2'd2;
          end else begin
            cell_nxt = out_rd_cell + CELL_IDX_WIDTH'(1);
            addr_nxt = '0;
            rden_nxt = 1'b1;
          end
        end else begin
          tmr_nxt = tmr - 2'd1;
        end
      end
      COOLDOWN: begin
        if (tmr == 2'd0) busy_nxt = 1'b0;
        else             tmr_nxt  = tmr - 2'd1;
      end
      default: ;
    endcase
  end

  // Control output and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_rd_cell              <= '0;
      out_rd_address           <= '0;
      out_rden                 <= 1'b0;
      out_motion_update_enable <= 1'b0;
      out_busy                 <= 1'b0;
      out_done                 <= 1'b0;
      rem                      <= '0;
      tmr                      <= 2'd0;
`ifdef MU_COUNT_CHECK_EN
      out_count_error          <= 1'b0;
`endif
    end else begin
      out_rd_cell              <= cell_nxt;
      out_rd_address           <= addr_nxt;
      out_rden                 <= rden_nxt;
      out_motion_update_enable <= en_nxt;
      out_busy                 <= busy_nxt;
      out_done                 <= done_nxt;
      rem                      <= rem_nxt;
      tmr                      <= tmr_nxt;
`ifdef MU_COUNT_CHECK_EN
      out_count_error          <= err_nxt;
`endif
    end
  end

  // Track particle reads through the 2-cycle cache latency and register the beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend              <= 2'b00;
      out_data_valid    <= 1'b0;
      out_data          <= '0;
      out_data_dst_cell <= '0;
    end else begin
      pend              <= {pend[0], state == PART_RD};
      out_data_valid    <= pend[1];
      out_data          <= pend[1] ? in_rd_data[3*DATA_WIDTH-1:0] : '0;
      out_data_dst_cell <= pend[1] ? in_rd_data[RD_W-1 -: 3*CELL_ID_WIDTH] : '0;
    end
  end

endmodule

// File: tb/tb_velocity_broadcast_ctrl.sv
// Bench for velocity_broadcast_ctrl: cache read-port responder, timing model
// derived from the per-cell cycle costs, table vectors, corner sequences and
// randomized walks.
`timescale 1ns/1ps
module tb_velocity_broadcast_ctrl;
  localparam int DW   = 32;
  localparam int AW   = 8;
  localparam int CW   = 4;
  localparam int PN   = 220;
  localparam int NC   = 2;
  localparam int CIW  = 3;
  localparam int RW   = 3*DW + 3*CW;
  localparam int MAXC = 1024;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_start = 1'b0;
  logic [CIW-1:0]  out_rd_cell;
  logic [AW-1:0]   out_rd_address;
  logic            out_rden;
  logic [RW-1:0]   in_rd_data = '0;
  logic            out_motion_update_enable;
  logic [3*DW-1:0] out_data;
  logic [3*CW-1:0] out_data_dst_cell;
  logic            out_data_valid;
  logic            out_busy;
  logic            out_done;
`ifdef MU_COUNT_CHECK_EN
  logic            out_count_error;
`endif

  velocity_broadcast_ctrl #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CELL_ID_WIDTH(CW),
    .PARTICLE_NUM(PN), .NUM_CELLS(NC), .CELL_IDX_WIDTH(CIW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_start(in_start),
    .out_rd_cell(out_rd_cell),
    .out_rd_address(out_rd_address),
    .out_rden(out_rden),
    .in_rd_data(in_rd_data),
    .out_motion_update_enable(out_motion_update_enable),
    .out_data(out_data),
    .out_data_dst_cell(out_data_dst_cell),
    .out_data_valid(out_data_valid),
    .out_busy(out_busy),
    .out_done(out_done)
`ifdef MU_COUNT_CHECK_EN
    ,
    .out_count_error(out_count_error)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [RW-1:0] mem [NC][256];
  int            cnt [NC];
  bit            exp_v [MAXC];
  logic [RW-1:0] exp_beat [MAXC];

  function automatic logic [RW-1:0] rnd_word();
    logic [127:0] w;
    w = {$urandom(), $urandom(), $urandom(), $urandom()};
    return w[RW-1:0];
  endfunction

  // Cache read ports behind the external mux: 2-cycle read latency, garbage otherwise
  logic           req_v = 1'b0;
  logic [CIW-1:0] req_cell = '0;
  logic [AW-1:0]  req_addr = '0;
  always @(posedge clk) begin
    req_v    <= out_rden;
    req_cell <= out_rd_cell;
    req_addr <= out_rd_address;
    if (req_v && int'(req_cell) < NC) in_rd_data <= mem[int'(req_cell)][req_addr];
    else                              in_rd_data <= rnd_word();
  end

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic int eff(input int n);
`ifdef MU_COUNT_CHECK_EN
    return (n > PN) ? PN : n;
`else
    return n;
`endif
  endfunction

  task automatic load_mem(input int c0, input int c1);
    logic [RW-1:0] w;
    cnt[0] = c0;
    cnt[1] = c1;
    for (int c = 0; c < NC; c++) begin
      for (int a = 0; a < 256; a++) begin
        w = rnd_word();
        w[AW-1:0] = AW'(a);
        mem[c][a] = w;
      end
      w = rnd_word();
      w[AW-1:0] = AW'(cnt[c]);
      mem[c][0] = w;
    end
  endtask

  // Expected beat schedule from the per-cell costs; returns the done cycle
  function automatic int build_model();
    int t, n, last_n;
    for (int i = 0; i < MAXC; i++) begin
      exp_v[i] = 1'b0;
      exp_beat[i] = '0;
    end
    t = 0;
    last_n = 0;
    for (int c = 0; c < NC; c++) begin
      n = eff(cnt[c]);
      for (int k = 1; k <= n; k++) begin
        exp_v[t+5+k] = 1'b1;
        exp_beat[t+5+k] = mem[c][k];
      end
      t = t + ((n == 0) ? 3 : n + 5);
      last_n = n;
    end
    return (last_n == 0) ? t : t + 1;
  endfunction

  task automatic pulse_start();
    @(negedge clk) in_start = 1'b1;
    @(negedge clk) in_start = 1'b0;
  endtask

  // One full walk, compared cycle by cycle; optional stray starts during walk and cooldown
  task automatic run_walk(input int c0, input int c1, input bit poke,
                          output int en_cycles, output int beats);
    int d;
    logic [111:0] got, exp;
    load_mem(c0, c1);
    d = build_model();
    pulse_start();
    en_cycles = 0;
    beats = 0;
    for (int c = 0; c < d + 6; c++) begin
      got = {out_motion_update_enable, out_data_valid, out_done, out_busy,
             out_data_dst_cell, out_data};
      exp = {(c < d), exp_v[c], (c == d), (c < d + 3),
             exp_v[c] ? exp_beat[c] : RW'(0)};
      check($sformatf("trace c=%0d", c), 128'(got), 128'(exp));
`ifdef MU_COUNT_CHECK_EN
      if (c == 0) check("count_error cleared at start", 128'(out_count_error), 128'(0));
`endif
      if (out_motion_update_enable) en_cycles++;
      if (out_data_valid) beats++;
      in_start = poke && (c == 4 || c == d + 2);
      @(negedge clk);
    end
    in_start = 1'b0;
`ifdef MU_COUNT_CHECK_EN
    check("count_error sticky", 128'(out_count_error), 128'((c0 > PN) || (c1 > PN)));
`endif
  endtask

  typedef struct {
    int c0;
    int c1;
    int beats;
    int en;
  } vec_t;

  vec_t vt[6];

  initial begin
    int en_cycles, beats, d, r, n0, n1;
    logic [127:0] z;

    vt[0] = '{3, 2, 5, 16};
    vt[1] = '{0, 0, 0, 6};
    vt[2] = '{220, 0, 220, 228};
    vt[3] = '{0, 1, 1, 10};
    vt[4] = '{1, 0, 1, 9};
`ifdef MU_COUNT_CHECK_EN
    vt[5] = '{250, 0, 220, 228};
`else
    vt[5] = '{250, 0, 250, 258};
`endif

    load_mem(0, 0);
    repeat (3) @(negedge clk);
    z = {out_busy, out_motion_update_enable, out_done, out_data_valid, out_rden,
         out_rd_address, out_rd_cell, out_data_dst_cell, out_data};
    check("reset state", z, 128'(0));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      run_walk(vt[i].c0, vt[i].c1, 1'b0, en_cycles, beats);
      check($sformatf("vec%0d beats", i), 128'(beats), 128'(vt[i].beats));
      check($sformatf("vec%0d enable cycles", i), 128'(en_cycles), 128'(vt[i].en));
    end

    // stray starts mid-walk and in the last cooldown cycle, then a real restart
    run_walk(3, 2, 1'b1, en_cycles, beats);
    check("poked walk beats", 128'(beats), 128'(5));
    run_walk(2, 1, 1'b0, en_cycles, beats);
    check("restart beats", 128'(beats), 128'(3));

    // reset in the middle of particle reads
    load_mem(220, 0);
    d = build_model();
    pulse_start();
    repeat (20) @(negedge clk);
    check("pre-reset valid", 128'(out_data_valid), 128'(exp_v[20]));
    #1 rst_n = 1'b0;
    #1;
    z = {out_busy, out_motion_update_enable, out_done, out_data_valid, out_rden,
         out_rd_address, out_rd_cell, out_data_dst_cell, out_data};
    check("async reset outputs", z, 128'(0));
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    check("no done after reset", 128'({out_done, out_busy}), 128'(0));
    run_walk(3, 2, 1'b0, en_cycles, beats);
    check("post-reset beats", 128'(beats), 128'(5));

    // randomized walks
    for (int it = 0; it < 25; it++) begin
      r = int'($urandom_range(0, 9));
      n0 = (r < 3) ? 0 : (r == 9) ? int'($urandom_range(200, 255)) : int'($urandom_range(1, 30));
      r = int'($urandom_range(0, 9));
      n1 = (r < 3) ? 0 : (r == 9) ? int'($urandom_range(200, 255)) : int'($urandom_range(1, 30));
      run_walk(n0, n1, 1'b0, en_cycles, beats);
      check($sformatf("rand%0d beats", it), 128'(beats), 128'(eff(n0) + eff(n1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
